// File: rtl/riscv_alu_ctrl_mc.sv
// Multi-cycle ALU controller: decodes OP / OP-IMM instructions into ALU select
// and writeback controls, and sequences M-extension ops through an external
// mul/div unit with a start/done handshake and a bounded wait.
module riscv_alu_ctrl_mc #(
  parameter int unsigned ENABLE_M     = 1,
  parameter int unsigned ENABLE_OPIMM = 1,
  parameter int unsigned MD_TIMEOUT   = 64,
  parameter int unsigned CNT_W        = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic        muldiv_done,
  output logic        muldiv_start,
  output logic        ctrl_valid,
  output logic [4:0]  alu_sel,
  output logic        alu_src,
  output logic        reg_wen,
  output logic        illegal,
  output logic        md_timeout
);

  typedef enum logic [0:0] {IDLE, MD_WAIT} state_t;

  localparam logic [6:0]       OPC_OP     = 7'b0110011;
  localparam logic [6:0]       OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0]       F7_BASE    = 7'b0000000;
  localparam logic [6:0]       F7_ALT     = 7'b0100000;
  localparam logic [6:0]       F7_MULDIV  = 7'b0000001;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(MD_TIMEOUT - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic              dec_legal;
  logic              dec_md;
  logic [4:0]        dec_sel;
  logic              dec_src;
  logic              fire;
  logic              unused_instr_bits;

  assign f3   = instr[14:12];
  assign f7   = instr[31:25];
  assign fire = instr_valid && instr_ready;

  // Register fields are not needed for control decode.
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  // Combinational decode of the offered instruction.
  always_comb begin
    dec_legal = 1'b0;
    dec_md    = 1'b0;
    dec_sel   = '0;
    dec_src   = 1'b0;
    case (instr[6:0])
      OPC_OP: begin
        if (f7 == F7_BASE) begin
          dec_legal = 1'b1;
          dec_sel   = {f3, 2'b00};
        end else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
          dec_legal = 1'b1;
          dec_sel   = {f3, 2'b10};
        end else if (f7 == F7_MULDIV && ENABLE_M != 0) begin
          dec_legal = 1'b1;
          dec_md    = 1'b1;
          dec_sel   = {f3, 2'b01};
        end
      end
      OPC_OPIMM: begin
        if (ENABLE_OPIMM != 0) begin
          dec_src = 1'b1;
          case (f3)
            3'b001: begin
              dec_legal = (f7 == F7_BASE);
              dec_sel   = 5'b00100;
            end
            3'b101: begin
              dec_legal = (f7 == F7_BASE) || (f7 == F7_ALT);
              dec_sel   = {3'b101, (f7 == F7_ALT), 1'b0};
            end
            default: begin
              dec_legal = 1'b1;
              dec_sel   = {f3, 2'b00};
            end
          endcase
        end
      end
      default: ;
    endcase
  end

  // Control FSM; every output is registered and pulses default low each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      instr_ready  <= 1'b1;
      muldiv_start <= 1'b0;
      ctrl_valid   <= 1'b0;
      alu_sel      <= '0;
      alu_src      <= 1'b0;
      reg_wen      <= 1'b0;
      illegal      <= 1'b0;
      md_timeout   <= 1'b0;
    end else begin
      muldiv_start <= 1'b0;
      ctrl_valid   <= 1'b0;
      reg_wen      <= 1'b0;
      illegal      <= 1'b0;
      md_timeout   <= 1'b0;
      case (state)
        IDLE: begin
          if (fire) begin
            if (!dec_legal) begin
              illegal <= 1'b1;
            end else if (dec_md) begin
              muldiv_start <= 1'b1;
              alu_sel      <= dec_sel;
              alu_src      <= dec_src;
              cnt          <= '0;
              instr_ready  <= 1'b0;
              state        <= MD_WAIT;
            end else begin
              ctrl_valid <= 1'b1;
              reg_wen    <= 1'b1;
              alu_sel    <= dec_sel;
              alu_src    <= dec_src;
            end
          end
        end
        MD_WAIT: begin
          cnt <= cnt + 1'b1;
          // done takes priority over an expiring wait in the same cycle
          if (muldiv_done) begin
            ctrl_valid  <= 1'b1;
            reg_wen     <= 1'b1;
            instr_ready <= 1'b1;
            state       <= IDLE;
          end else if (cnt == CNT_LAST) begin
            md_timeout  <= 1'b1;
            instr_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
